// File: rtl/logic_processor_n.sv
// rtl/logic_processor_n.sv - bit-serial logic processor: applies F to A and B one bit per clock, LSB first, and routes the result per R
module logic_processor_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             LoadA,
    input  logic             LoadB,
    input  logic             Execute,
    input  logic [WIDTH-1:0] Din,
    input  logic [2:0]       F,
    input  logic [1:0]       R,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f_q;
    logic [1:0]       r_q;

    logic bit_a;
    logic bit_b;
    logic f_bit;
    logic new_a;
    logic new_b;

    function automatic logic bit_func(input logic [2:0] sel, input logic a, input logic b);
        logic res;
        case (sel)
            3'b000:  res = a & b;
            3'b001:  res = a | b;
            3'b010:  res = a ^ b;
            3'b011:  res = 1'b1;
            3'b100:  res = ~(a & b);
            3'b101:  res = ~(a | b);
            3'b110:  res = ~(a ^ b);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    always_comb begin
        bit_a = a_q[0];
        bit_b = b_q[0];
        f_bit = bit_func(f_q, bit_a, bit_b);
        new_a = bit_a;
        new_b = bit_b;
        case (r_q)
            2'b01: new_b = f_bit;
            2'b10: new_a = f_bit;
            2'b11: begin
                new_a = bit_b;
                new_b = bit_a;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
            f_q   <= '0;
            r_q   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A load in the same cycle as Execute defers the start by one edge.
                    if (LoadA || LoadB) begin
                        if (LoadA) a_q <= Din;
                        if (LoadB) b_q <= Din;
                    end else if (Execute) begin
                        state <= S_SHIFT;
                        f_q   <= F;
                        r_q   <= R;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    a_q <= {new_a, a_q[WIDTH-1:1]};
                    b_q <= {new_b, b_q[WIDTH-1:1]};
                    if (cnt == CNT_LAST) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (LoadA) a_q <= Din;
                    if (LoadB) b_q <= Din;
                    if (!Execute) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Aval = a_q;
    assign Bval = b_q;

endmodule

// File: doc/logic_processor_n.md
# logic_processor_n

Parametrised bit-serial logic processor: two WIDTH-bit registers A and B and a control FSM. On Execute, the block applies one of eight bitwise functions to A and B one bit per clock, LSB first, and routes the result back into A and/or B. It is the generalised successor of the fixed 8-bit lab processor and has these additions:
- width is set by a parameter;
- F and R are captured when execution starts;
- the block reports status through Busy and Done outputs.

It sits between the board-level input synchronizers and the hex-display drivers.

## Interface
- WIDTH, 8, register width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the shift counter; derived, do not override.

- Clk  in  1  system clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- LoadA  in  1  active-high, synchronized: load Din into A.
- LoadB  in  1  active-high, synchronized: load Din into B.
- Execute  in  1  active-high, synchronized level: start one serial operation.
- Din  in  WIDTH  parallel load data.
- F  in  3  function select.
- R  in  2  routing select.
- Aval  out  WIDTH  current contents of A.
- Bval  out  WIDTH  current contents of B.
- Busy  out  1  high while shifting.
- Done  out  1  one-cycle pulse when an operation completes.

## Operation
- FSM has three states:
  - IDLE: waiting for a load or Execute.
  - SHIFT: serial operation in progress.
  - HOLD: operation finished; waiting for Execute to be released.
- IDLE transitions:
  - LoadA and/or LoadB high: the selected register(s) load Din. Both may load in the same cycle. Stay in IDLE.
  - Execute high with no load: go to SHIFT, latch F into F_q and R into R_q, clear the counter.
  - Load and Execute high together: the load wins and no start occurs that cycle. If Execute is still high on the next edge, the operation starts then.
- SHIFT, once per cycle:
  - bitA = A[0], bitB = B[0], f = F_q(bitA, bitB).
  - Routing by R_q: 00 → newA=bitA, newB=bitB. 01 → newA=bitA, newB=f. 10 → newA=f, newB=bitB. 11 → newA=bitB, newB=bitA.
  - Update: A <= {newA, A[WIDTH-1:1]}, B <= {newB, B[WIDTH-1:1]}, counter increments.
  - When counter == WIDTH-1 on that edge, go to HOLD.
- F encoding: 000 AND, 001 OR, 010 XOR, 011 all-ones, 100 NAND, 101 NOR, 110 XNOR, 111 all-zeros.
- After WIDTH shifts, each register holds either its original value (rotated fully around) or the bitwise result, as selected by R_q.
- HOLD: stay while Execute is high. Go to IDLE when Execute is low. Loads are honored in HOLD.
- In SHIFT, LoadA, LoadB, F, R and Execute are all ignored.

## Timing
- Reset (Reset_n low, asynchronous, at any time, including mid-SHIFT): A=0, B=0, state=IDLE, counter=0, F_q=0, R_q=0, Busy=0, Done=0. A partial operation is discarded, not resumed.
- Loads: Aval/Bval reflect Din on the cycle after the edge that sampled the load.
- Start: the edge that samples Execute=1 in IDLE is edge 0. Shift edges are 1..WIDTH.
  - Busy=1 from after edge 0 through edge WIDTH; it is a registered output decoded from state==SHIFT.
  - The final result is visible after edge WIDTH.
- Done=1 for exactly the one cycle after edge WIDTH; it is registered and set on the SHIFT→HOLD transition.
- Execute held for many cycles runs exactly one operation. A second operation needs Execute low for at least one edge (HOLD→IDLE) and then high again.
- F or R changing during SHIFT has no effect on the result.
- Counter wrap: the counter never exceeds WIDTH-1. This includes non-power-of-two WIDTH values such as 5.
- Aval and Bval are direct register outputs with no combinational path from inputs.

## Test plan
All scenarios use WIDTH=8 unless noted.

1. Reset_n low → Aval=0x00, Bval=0x00, Busy=0, Done=0.
   Then LoadA with Din=0xA5 and LoadB with Din=0x3C in the same cycle → Aval=0xA5, Bval=0x3C next cycle.
2. From A=0xA5, B=0x3C:
   - F=000, R=10, Execute pulse → after 8 shift cycles A=0x24, B=0x3C. Busy high exactly 8 cycles; Done a one-cycle pulse in cycle 9.
   - F=010, R=01 → A=0xA5, B=0x99.
3. From A=0xA5, B=0x3C:
   - R=11 → A=0x3C, B=0xA5.
   - R=00 → both registers unchanged.
   - F=011, R=10 → A=0xFF.
   - F=111, R=01 → B=0x00.
4. Execute held 30 cycles → exactly one operation and one Done pulse.
   Changing F from 000 to 001 at shift cycle 3 → result equals the pure-AND value (A=0x24).
5. LoadA with Din=0xFF asserted in shift cycle 4 → ignored; the operation completes normally.
   Reset_n low at shift cycle 5 → immediately A=0, B=0, Busy=0. After release, state is IDLE and no Done pulse occurs.
6. WIDTH=5, A=0x15, B=0x0F, F=001, R=10 → A=0x1F after exactly 5 shifts. Done pulses once and the counter does not wrap past 4.
